// File: rtl/train_sequencer_if.sv
// Handshake bundle between train_sequencer and its datapath / controller.
// The slave modport is the sequencer view; the master modport is the driver view.
interface train_sequencer_if #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned N_SAMPLES = 16,
  parameter int unsigned N_EPOCHS  = 8
);
  localparam int unsigned SAMPLE_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int unsigned EPOCH_W  = $clog2(N_EPOCHS + 1);

  logic                       i_start;
  logic                       i_fwd_done;
  logic                       i_bwd_done;
  logic                       i_upd_done;
  logic signed [WIDTH-1:0]    i_cost;

  logic                       o_fwd_start;
  logic                       o_bwd_start;
  logic                       o_upd_start;
  logic        [SAMPLE_W-1:0] o_sample;
  logic        [EPOCH_W-1:0]  o_epoch;
  logic                       o_busy;
  logic                       o_stop;
  logic signed [WIDTH-1:0]    o_cost;

  modport slave (
    input  i_start, i_fwd_done, i_bwd_done, i_upd_done, i_cost,
    output o_fwd_start, o_bwd_start, o_upd_start, o_sample, o_epoch, o_busy, o_stop, o_cost
  );

  modport master (
    output i_start, i_fwd_done, i_bwd_done, i_upd_done, i_cost,
    input  o_fwd_start, o_bwd_start, o_upd_start, o_sample, o_epoch, o_busy, o_stop, o_cost
  );
endinterface

// File: rtl/train_sequencer.sv
// Training-loop sequencer: for each sample it fires forward, backward and update phase-start
// pulses, waits for each phase's done pulse, and accumulates the per-sample cost with signed
// saturation. At the end of every epoch the sum is published on o_cost. The run ends after
// N_EPOCHS epochs, or earlier when the optional early-stop feature is compiled in.
// Optional feature: define TRAIN_SEQUENCER_EARLY_STOP_EN to end the run at any epoch whose
// cost sum is below COST_THRESH.
module train_sequencer #(
  parameter int unsigned             WIDTH       = 24,
  parameter int unsigned             N_SAMPLES   = 16,
  parameter int unsigned             N_EPOCHS    = 8,
  parameter logic signed [WIDTH-1:0] COST_THRESH = 24'sd256
) (
  input  logic              clk,
  input  logic              rst,
  train_sequencer_if.slave  io_bus
);

  localparam int unsigned SAMPLE_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int unsigned EPOCH_W  = $clog2(N_EPOCHS + 1);

  localparam logic signed [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    StIdle,
    StFwd,
    StWaitFwd,
    StBwd,
    StWaitBwd,
    StUpd,
    StWaitUpd,
    StNext,
    StDone
  } state_e;

  state_e                  r_state;
  state_e                  w_state_d;

  logic [SAMPLE_W-1:0]     r_sample;
  logic [SAMPLE_W-1:0]     w_sample_d;
  logic [EPOCH_W-1:0]      r_epoch;
  logic [EPOCH_W-1:0]      w_epoch_d;
  logic signed [WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0] w_acc_d;
  logic signed [WIDTH-1:0] r_cost;
  logic signed [WIDTH-1:0] w_cost_d;

  logic                    r_fwd_start;
  logic                    r_bwd_start;
  logic                    r_upd_start;
  logic                    r_busy;
  logic                    r_stop;

  logic [WIDTH:0]          w_sum_ext;
  logic signed [WIDTH-1:0] w_sum_sat;
  logic [EPOCH_W-1:0]      w_epoch_inc;
  logic                    w_last_sample;
  logic                    w_last_epoch;
  logic                    w_end_run;

  // One extra bit of headroom: the top two bits disagree exactly when the add overflowed.
  assign w_sum_ext = {r_acc[WIDTH-1], r_acc} + {io_bus.i_cost[WIDTH-1], io_bus.i_cost};

  // Clamp the accumulator update to the signed WIDTH range.
  always_comb begin
    w_sum_sat = w_sum_ext[WIDTH-1:0];
    if (w_sum_ext[WIDTH] != w_sum_ext[WIDTH-1]) begin
      w_sum_sat = w_sum_ext[WIDTH] ? SatMin : SatMax;
    end
  end

  assign w_epoch_inc   = r_epoch + 1'b1;
  assign w_last_sample = (r_sample == SAMPLE_W'(N_SAMPLES - 1));
  assign w_last_epoch  = (w_epoch_inc == EPOCH_W'(N_EPOCHS));

`ifdef TRAIN_SEQUENCER_EARLY_STOP_EN
  // r_acc holds the finished epoch sum while in StNext.
  assign w_end_run = w_last_epoch | (r_acc < COST_THRESH);
`else
  assign w_end_run = w_last_epoch;
`endif

  // Next-state and next-value logic for the sequencer and its counters.
  always_comb begin
    w_state_d  = r_state;
    w_sample_d = r_sample;
    w_epoch_d  = r_epoch;
    w_acc_d    = r_acc;
    w_cost_d   = r_cost;

    unique case (r_state)
      StIdle: begin
        if (io_bus.i_start) begin
          w_state_d  = StFwd;
          w_sample_d = '0;
          w_epoch_d  = '0;
          w_acc_d    = '0;
        end
      end
      StFwd: w_state_d = StWaitFwd;
      StWaitFwd: begin
        if (io_bus.i_fwd_done) begin
          w_acc_d   = w_sum_sat;
          w_state_d = StBwd;
        end
      end
      StBwd: w_state_d = StWaitBwd;
      StWaitBwd: begin
        if (io_bus.i_bwd_done) begin
          w_state_d = StUpd;
        end
      end
      StUpd: w_state_d = StWaitUpd;
      StWaitUpd: begin
        if (io_bus.i_upd_done) begin
          w_state_d = StNext;
        end
      end
      StNext: begin
        if (!w_last_sample) begin
          w_sample_d = r_sample + 1'b1;
          w_state_d  = StFwd;
        end else begin
          w_cost_d   = r_acc;
          w_epoch_d  = w_epoch_inc;
          w_acc_d    = '0;
          w_sample_d = '0;
          w_state_d  = w_end_run ? StDone : StFwd;
        end
      end
      StDone: begin
        // Wait for the requester to drop i_start so one request never launches two runs.
        if (!io_bus.i_start) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Sample/epoch counters, cost accumulator and published epoch cost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_epoch  <= '0;
      r_acc    <= '0;
      r_cost   <= '0;
    end else begin
      r_sample <= w_sample_d;
      r_epoch  <= w_epoch_d;
      r_acc    <= w_acc_d;
      r_cost   <= w_cost_d;
    end
  end

  // Registered status and strobes, decoded from the next state so they align with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_start <= 1'b0;
      r_bwd_start <= 1'b0;
      r_upd_start <= 1'b0;
      r_busy      <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_fwd_start <= (w_state_d == StFwd);
      r_bwd_start <= (w_state_d == StBwd);
      r_upd_start <= (w_state_d == StUpd);
      r_busy      <= (w_state_d != StIdle) && (w_state_d != StDone);
      r_stop      <= (w_state_d == StDone);
    end
  end

  assign io_bus.o_fwd_start = r_fwd_start;
  assign io_bus.o_bwd_start = r_bwd_start;
  assign io_bus.o_upd_start = r_upd_start;
  assign io_bus.o_sample    = r_sample;
  assign io_bus.o_epoch     = r_epoch;
  assign io_bus.o_busy      = r_busy;
  assign io_bus.o_stop      = r_stop;
  assign io_bus.o_cost      = r_cost;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer with N_SAMPLES=4, N_EPOCHS=2, WIDTH=24.
// A small responder answers each phase-start pulse with a done pulse two cycles later.
module tb_train_sequencer;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned NS    = 4;
  localparam int unsigned NE    = 2;

`ifdef TRAIN_SEQUENCER_EARLY_STOP_EN
  localparam int EARLY_EP = 1;
`else
  localparam int EARLY_EP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int n_fwd = 0;
  int n_bwd = 0;
  int n_upd = 0;

  train_sequencer_if #(.WIDTH(WIDTH), .N_SAMPLES(NS), .N_EPOCHS(NE)) bus ();

  train_sequencer #(
    .WIDTH      (WIDTH),
    .N_SAMPLES  (NS),
    .N_EPOCHS   (NE),
    .COST_THRESH(24'sd256)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Running totals of start pulses, one per cycle seen high.
  always @(negedge clk) begin
    n_fwd <= n_fwd + int'(bus.o_fwd_start);
    n_bwd <= n_bwd + int'(bus.o_bwd_start);
    n_upd <= n_upd + int'(bus.o_upd_start);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic start_of(input int which);
    case (which)
      0:       return bus.o_fwd_start;
      1:       return bus.o_bwd_start;
      default: return bus.o_upd_start;
    endcase
  endfunction

  task automatic set_done(input int which, input logic val);
    case (which)
      0:       bus.i_fwd_done = val;
      1:       bus.i_bwd_done = val;
      default: bus.i_upd_done = val;
    endcase
  endtask

  // Wait (bounded) for the start pulse of one phase, then answer it 2 cycles later.
  task automatic phase(input int which, input logic signed [23:0] cost, input bit stray,
                       input int exp_sample, input int exp_epoch);
    bit ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (start_of(which) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    check_val("start_seen", 32'(ok), 32'd1);
    if (ok) begin
      if (which == 0) begin
        check_val("sample_idx", 32'(bus.o_sample), 32'(exp_sample));
        check_val("epoch_idx", 32'(bus.o_epoch), 32'(exp_epoch));
      end
      @(negedge clk);
      if (stray) begin
        bus.i_bwd_done = 1'b1;
        bus.i_upd_done = 1'b1;
      end
      @(negedge clk);
      if (stray) begin
        bus.i_bwd_done = 1'b0;
        bus.i_upd_done = 1'b0;
        check_val("stray_quiet",
                  {28'd0, bus.o_busy, bus.o_fwd_start, bus.o_bwd_start, bus.o_upd_start},
                  32'b1000);
      end
      set_done(which, 1'b1);
      bus.i_cost = cost;
      @(negedge clk);
      set_done(which, 1'b0);
      bus.i_cost = '0;
    end
  endtask

  // Drive a run with i_start held high; abort_at > 0 returns after that many samples.
  task automatic run(input logic signed [23:0] cost, input int n_ep,
                     input logic signed [23:0] exp_cost, input bit stray, input int abort_at);
    int  n_done = 0;
    bit  quit   = 1'b0;
    bus.i_start = 1'b1;
    for (int e = 0; e < n_ep && !quit; e++) begin
      for (int s = 0; s < int'(NS) && !quit; s++) begin
        phase(0, cost, stray && (e == 0) && (s == 1), s, e);
        check_val("lat_bwd", 32'(bus.o_bwd_start), 32'd1);
        phase(1, 24'sd0, 1'b0, s, e);
        check_val("lat_upd", 32'(bus.o_upd_start), 32'd1);
        phase(2, 24'sd0, 1'b0, s, e);
        check_val("next_gap", {30'd0, bus.o_busy, bus.o_fwd_start}, 32'b10);
        n_done++;
        if (n_done == abort_at) begin
          quit = 1'b1;
        end else if (s == int'(NS) - 1) begin
          @(negedge clk);
          check_val("epoch_cnt", 32'(bus.o_epoch), 32'(e + 1));
          check_val("epoch_cost", 32'(bus.o_cost), 32'(exp_cost));
          check_val("sample_wrap", 32'(bus.o_sample), 32'd0);
          if (e == n_ep - 1) check_val("stop_busy", {30'd0, bus.o_stop, bus.o_busy}, 32'b10);
          else check_val("lat_epoch", {30'd0, bus.o_busy, bus.o_fwd_start}, 32'b11);
        end
      end
    end
  endtask

  task automatic to_idle();
    bus.i_start = 1'b0;
    @(negedge clk);
    check_val("idle_after_done", {30'd0, bus.o_stop, bus.o_busy}, 32'b00);
  endtask

  int f0, b0, u0;

  initial begin
    bus.i_start    = 1'b0;
    bus.i_fwd_done = 1'b0;
    bus.i_bwd_done = 1'b0;
    bus.i_upd_done = 1'b0;
    bus.i_cost     = '0;

    // Reset state.
    @(negedge clk);
    check_val("rst_flags", {27'd0, bus.o_fwd_start, bus.o_bwd_start, bus.o_upd_start,
                            bus.o_busy, bus.o_stop}, 32'd0);
    check_val("rst_sample", 32'(bus.o_sample), 32'd0);
    check_val("rst_epoch", 32'(bus.o_epoch), 32'd0);
    check_val("rst_cost", 32'(bus.o_cost), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // No run without i_start.
    repeat (3) @(negedge clk);
    check_val("idle_no_start", {30'd0, bus.o_busy, bus.o_fwd_start}, 32'b00);

    // Full run, cost 100 per sample, stray dones during one WAIT_FWD.
    f0 = n_fwd; b0 = n_bwd; u0 = n_upd;
    run(24'sd100, 2, 24'sd400, 1'b1, 0);
    repeat (4) @(negedge clk);
    check_val("stop_held", {30'd0, bus.o_stop, bus.o_busy}, 32'b10);
    check_val("epoch_held", 32'(bus.o_epoch), 32'd2);
    check_val("cost_held", 32'(bus.o_cost), 32'(24'sd400));
    check_val("n_fwd", 32'(n_fwd - f0), 32'd8);
    check_val("n_bwd", 32'(n_bwd - b0), 32'd8);
    check_val("n_upd", 32'(n_upd - u0), 32'd8);

    // Restart and positive saturation.
    to_idle();
    run(24'sh7FFFFF, 2, 24'sh7FFFFF, 1'b0, 0);

    // Negative saturation (below threshold, so early stop ends it after one epoch).
    to_idle();
    run(-24'sh800000, EARLY_EP, -24'sh800000, 1'b0, 0);

    // Early stop: sum 200 < 256.
    to_idle();
    run(24'sd50, EARLY_EP, 24'sd200, 1'b0, 0);
    check_val("early_epoch", 32'(bus.o_epoch), 32'(EARLY_EP));

    // Reset during sample 2 of epoch 1.
    to_idle();
    run(24'sd100, 2, 24'sd400, 1'b0, 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_flags", {27'd0, bus.o_fwd_start, bus.o_bwd_start, bus.o_upd_start,
                               bus.o_busy, bus.o_stop}, 32'd0);
    check_val("midrst_cnt", {bus.o_sample, bus.o_epoch}, 32'd0);
    check_val("midrst_cost", 32'(bus.o_cost), 32'd0);
    bus.i_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    f0 = n_fwd;
    repeat (3) @(negedge clk);
    check_val("midrst_quiet", {31'd0, bus.o_busy}, 32'd0);
    check_val("midrst_nofwd", 32'(n_fwd - f0), 32'd0);
    run(24'sd100, 2, 24'sd400, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/train_sequencer.md
TRAIN_SEQUENCER -- requirements
Module: train_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 24, signed cost word width.
REQ-002 SHALL have parameter N_SAMPLES, default 16, samples per epoch (>=1).
REQ-003 SHALL have parameter N_EPOCHS, default 8, epochs per run (>=1).
REQ-004 SHALL have parameter COST_THRESH, default 24'sd256, early-stop threshold (signed WIDTH).
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: i_start in 1, run request (level); i_fwd_done, i_bwd_done, i_upd_done in 1 each, datapath phase-complete pulses.
REQ-007 SHALL have ports: i_cost in WIDTH signed, sample cost, valid with i_fwd_done.
REQ-008 SHALL have ports: o_fwd_start, o_bwd_start, o_upd_start out 1 each, one-cycle phase-start pulses.
REQ-009 SHALL have ports: o_sample out clog2(N_SAMPLES) (min 1), current sample index; o_epoch out clog2(N_EPOCHS+1), completed-epoch count.
REQ-010 SHALL have ports: o_busy out 1; o_stop out 1, run finished; o_cost out WIDTH signed, last completed epoch cost sum.

Function
REQ-011 SHALL implement states IDLE, FWD, WAIT_FWD, BWD, WAIT_BWD, UPD, WAIT_UPD, NEXT, DONE; all outputs registered.
REQ-012 SHALL move IDLE->FWD when i_start=1, clearing o_sample, o_epoch and the internal accumulator.
REQ-013 SHALL assert o_fwd_start/o_bwd_start/o_upd_start for exactly the single cycle spent in FWD/BWD/UPD, then enter the matching WAIT state.
REQ-014 SHALL leave WAIT_x only on the cycle its own done input is 1; done inputs outside their WAIT state SHALL be ignored.
REQ-015 SHALL, on i_fwd_done in WAIT_FWD, add i_cost to the accumulator with signed saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-016 SHALL go WAIT_UPD->NEXT on i_upd_done; NEXT with o_sample<N_SAMPLES-1 SHALL increment o_sample and go to FWD.
REQ-017 SHALL, in NEXT with o_sample=N_SAMPLES-1: copy accumulator to o_cost, increment o_epoch, clear accumulator, wrap o_sample to 0.
REQ-018 SHALL, at that epoch end, go to DONE if new o_epoch=N_EPOCHS, otherwise to FWD.
REQ-019 SHALL hold o_stop=1 and o_busy=0 in DONE; DONE SHALL remain while i_start=1 and return to IDLE when i_start=0 (o_stop cleared on exit).
REQ-020 SHALL hold o_busy=1 in every state except IDLE and DONE.
REQ-021 SHALL ignore i_start deassertion while busy; a run always completes.
REQ-022 SHALL give phase-start latency of one cycle: done pulse at cycle t -> next start pulse at t+1 (t+2 when passing through NEXT).

Reset
REQ-023 SHALL, on rst=1 at any time including mid-run, enter IDLE asynchronously with all outputs 0 and accumulator 0.
REQ-024 SHALL start no run on the first rising clk edge after rst release unless i_start=1 at that edge.

Configuration
REQ-025 SHALL compile early stop with macro TRAIN_SEQUENCER_EARLY_STOP_EN: when defined, epoch end with epoch sum < COST_THRESH SHALL go to DONE regardless of o_epoch; when undefined, COST_THRESH is unused and only N_EPOCHS ends the run.

Verification (N_SAMPLES=4, N_EPOCHS=2, WIDTH=24)
REQ-026 SHALL cover full run: i_start held 1, done pulses 2 cycles after each start, i_cost=100 -> 8 fwd/bwd/upd pulses each, o_cost=400, o_epoch=2, o_stop=1 and held.
REQ-027 SHALL cover saturation: i_cost=24'sh7FFFFF every sample -> o_cost=24'sh7FFFFF; i_cost=-24'sh800000 -> o_cost=-24'sh800000.
REQ-028 SHALL cover stray dones: i_bwd_done and i_upd_done pulsed during WAIT_FWD -> no state change, no extra start pulse.
REQ-029 SHALL cover reset mid-run: rst at sample 2 of epoch 1 -> all outputs 0 immediately, no start pulses until i_start re-sampled.
REQ-030 SHALL cover early stop (macro defined, COST_THRESH=256): epoch 1 i_cost=50 -> o_stop=1 after epoch 1, o_epoch=1, o_cost=200; macro undefined -> run continues to o_epoch=2.
REQ-031 SHALL cover restart: i_start dropped in DONE then reasserted -> IDLE, new run with o_epoch and o_sample restarting at 0.
